// File: rtl/bcd_pkg.sv
// Shared BCD types, FSM states and digit helpers for the serial BCD add/subtract controller.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  function automatic bcd_digit_t nines_comp(bcd_digit_t d);
    return BCD_NINE - d;
  endfunction

  function automatic logic digit_invalid(bcd_digit_t d);
    return (d > BCD_NINE);
  endfunction

endpackage

// File: rtl/BCD_Adder_4bit.sv
// Single-digit BCD adder cell: binary add of two digits plus carry, then +6 correction above 9.
module BCD_Adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_bin;

  assign w_bin  = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
  assign o_cout = (w_bin > 5'd9);
  assign o_sum  = o_cout ? (w_bin[3:0] + 4'd6) : w_bin[3:0];

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial multi-digit BCD add/subtract: one shared digit cell, LSD first, carry held in a register.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS);

  state_t           r_state;
  logic [W-1:0]     r_opA;
  logic [W-1:0]     r_opB;
  logic [W-1:0]     r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  bcd_digit_t       w_dSum;
  logic             w_dCout;
  logic [W-1:0]     w_bLoad;
  logic             w_err;

  BCD_Adder_4bit u_digit (
    .i_a    (r_opA[3:0]),
    .i_b    (r_opB[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dSum),
    .o_cout (w_dCout)
  );

  // Subtraction is a + 9's complement of b + 1; invalid digits are flagged on the raw operands.
  always_comb begin
    w_bLoad = '0;
    w_err   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_bLoad[4*i +: 4] = op_sub ? nines_comp(b[4*i +: 4]) : b[4*i +: 4];
      w_err = w_err | digit_invalid(a[4*i +: 4]) | digit_invalid(b[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_opA   <= '0;
      r_opB   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_opA   <= a;
            r_opB   <= w_bLoad;
            r_carry <= op_sub ? 1'b1 : cin;
            r_cnt   <= '0;
            err     <= w_err;
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // New digits enter at the top so digit 0 lands at [3:0] after the last shift.
          r_res   <= {w_dSum, r_res[W-1:4]};
          r_opA   <= r_opA >> 4;
          r_opB   <= r_opB >> 4;
          r_carry <= w_dCout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIGITS - 1)) begin
            sum     <= {w_dSum, r_res[W-1:4]};
            cout    <= w_dCout;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: decimal reference model, queued expectations, done-driven monitor.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Edge counter: after the edge that samples start it holds that edge's index.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           doneCyc;
  } exp_t;

  exp_t         sbq[$];
  exp_t         monE;
  int           checks   = 0;
  int           failures = 0;
  logic         heldValid = 1'b0;
  logic [W-1:0] heldSum   = '0;

  function automatic longint bcdToInt(logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] intToBcd(longint n);
    logic [W-1:0] r = '0;
    longint m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic anyBad(logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Decimal arithmetic on whole numbers; done is expected DIGITS edges after the accepting edge.
  function automatic exp_t model(logic [W-1:0] ia, logic [W-1:0] ib, logic isub, logic icin, int acceptCyc);
    exp_t   e;
    longint pw = 1;
    longint va = bcdToInt(ia);
    longint vb = bcdToInt(ib);
    longint t;
    for (int i = 0; i < DIGITS; i++) pw = pw * 10;
    e.err     = anyBad(ia) | anyBad(ib);
    e.doneCyc = acceptCyc + DIGITS;
    if (!isub) begin
      t      = va + vb + longint'(icin);
      e.cout = (t >= pw);
      e.sum  = intToBcd(t % pw);
    end else if (va >= vb) begin
      e.cout = 1'b1;
      e.sum  = intToBcd(va - vb);
    end else begin
      e.cout = 1'b0;
      e.sum  = intToBcd(pw - (vb - va));
    end
    return e;
  endfunction

  function automatic logic [W-1:0] randBcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just before the earliest next accept.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic isub, input logic icin, input logic pulses);
    checkOutput("readyBeforeStart", {31'd0, ready}, 32'd1);
    a = ia; b = ib; op_sub = isub; cin = icin;
    start     = 1'b1;
    heldValid = 1'b0;
    sbq.push_back(model(ia, ib, isub, icin, cyc + 1));
    for (int j = 0; j < DIGITS + 2; j++) begin
      @(negedge clk);
      start = pulses && (j == 1 || j == DIGITS);
      if (start) a = ~ia;
    end
  endtask

  task automatic applyHeld(input logic [W-1:0] ia, input logic [W-1:0] ib, input int n);
    int k;
    checkOutput("readyBeforeHeld", {31'd0, ready}, 32'd1);
    a = ia; b = ib; op_sub = 1'b0; cin = 1'b1;
    start     = 1'b1;
    heldValid = 1'b0;
    k = cyc + 1;
    for (int j = 0; j < n; j++) sbq.push_back(model(ia, ib, 1'b0, 1'b1, k + j * (DIGITS + 2)));
    repeat ((n - 1) * (DIGITS + 2) + 1) @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);
  endtask

  task automatic applyAbort(input logic [W-1:0] ia, input logic [W-1:0] ib);
    a = ia; b = ib; op_sub = 1'b0; cin = 1'b0;
    start     = 1'b1;
    heldValid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortReady", {31'd0, ready}, 32'd1);
    checkOutput("abortBusy",  {31'd0, busy},  32'd0);
    checkOutput("abortDone",  {31'd0, done},  32'd0);
    checkOutput("abortSum",   32'(sum),       32'd0);
    checkOutput("abortCout",  {31'd0, cout},  32'd0);
    heldSum   = '0;
    heldValid = 1'b1;
    repeat (DIGITS + 2) @(negedge clk);
  endtask

  // Monitor: every done pops one expectation; between operations the result must not move.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedDone: got done=1 expected no pending operation (cycle %0d)", cyc);
        end else begin
          monE = sbq.pop_front();
          checkOutput("doneCycle", 32'(cyc), 32'(monE.doneCyc));
          checkOutput("err", {31'd0, err}, {31'd0, monE.err});
          checkOutput("flagsOnDone", {30'd0, ready, busy}, 32'd0);
          if (!monE.err) begin
            checkOutput("sum",  32'(sum),       32'(monE.sum));
            checkOutput("cout", {31'd0, cout},  {31'd0, monE.cout});
          end
          heldSum   = monE.err ? sum : monE.sum;
          heldValid = 1'b1;
        end
      end else if (heldValid) begin
        checkOutput("sumHeld", 32'(sum), 32'(heldSum));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("resetReady", {31'd0, ready}, 32'd1);
    checkOutput("resetBusy",  {31'd0, busy},  32'd0);
    checkOutput("resetDone",  {31'd0, done},  32'd0);
    checkOutput("resetSum",   32'(sum),       32'd0);
    checkOutput("resetCout",  {31'd0, cout},  32'd0);
    checkOutput("resetErr",   {31'd0, err},   32'd0);
    heldSum   = '0;
    heldValid = 1'b1;

    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0500, 16'h0123, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0123, 16'h0500, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'h4321, 16'h4321, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0042, 16'h0058, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h3141, 16'h2718, 1'b0, 1'b0, 1'b1);
    applyHeld(16'h2468, 16'h1357, 3);
    applyAbort(16'h1111, 16'h2222);
    applyStimulus(16'h8765, 16'h4321, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      applyStimulus(randBcd(), randBcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending operations expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
